// File: rtl/kernel_bc_start_token_issuer_if.sv
// Block-level handshake and start-FIFO write bundle for kernel_bc_start_token_issuer.
// The slave modport is the issuer's view; master is the surrounding controller/FIFOs.
interface kernel_bc_start_token_issuer_if #(
    parameter int unsigned NUM_OUT = 2
);
    logic               ap_start;
    logic               ap_ready;
    logic               ap_idle;
    logic               ap_done;
    logic               ap_continue;
    logic               core_start;
    logic               core_done;
    logic [NUM_OUT-1:0] start_full_n;
    logic [NUM_OUT-1:0] start_write;
    logic [NUM_OUT-1:0] start_out;

    modport slave (
        input  ap_start, ap_continue, core_done, start_full_n,
        output ap_ready, ap_idle, ap_done, core_start, start_write, start_out
    );

    modport master (
        output ap_start, ap_continue, core_done, start_full_n,
        input  ap_ready, ap_idle, ap_done, core_start, start_write, start_out
    );
endinterface

// File: rtl/kernel_bc_start_token_issuer.sv
// Issues one start token per task to each downstream start FIFO, then launches the body.
// Define KERNEL_BC_START_STALL_CNT_EN to build the saturating back-pressure counter.
module kernel_bc_start_token_issuer #(
    parameter int unsigned NUM_OUT   = 2,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    kernel_bc_start_token_issuer_if.slave bus,
    output logic [CNT_WIDTH-1:0]          task_count,
    output logic [CNT_WIDTH-1:0]          stall_cycles
);

    typedef enum logic [1:0] {StIdle, StIssue, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [NUM_OUT-1:0]   sent_q, sent_d;
    logic [NUM_OUT-1:0]   write;
    logic                 ready;
    logic                 core_start_q;
    logic [CNT_WIDTH-1:0] task_count_q;

    always_comb begin
        state_d = state_q;
        sent_d  = sent_q;
        write   = '0;
        ready   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.ap_start) begin
                    sent_d  = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // Only outstanding tokens whose FIFO has room this cycle are written.
                write  = ~sent_q & bus.start_full_n;
                sent_d = sent_q | write;
                if (&sent_d) begin
                    ready   = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.core_done) state_d = StDone;
            end
            StDone: begin
                if (bus.ap_continue) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            sent_q       <= '0;
            core_start_q <= 1'b0;
            task_count_q <= '0;
        end else begin
            state_q      <= state_d;
            sent_q       <= sent_d;
            core_start_q <= ready;
            if (state_q == StDone && bus.ap_continue) task_count_q <= task_count_q + 1'b1;
        end
    end

`ifdef KERNEL_BC_START_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_q;
    logic                 stall_hit;

    assign stall_hit = (state_q == StIssue) && (|(~sent_q & ~bus.start_full_n));

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (stall_hit && !(&stall_q)) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

    assign bus.start_write = write;
    assign bus.ap_ready    = ready;
    assign bus.start_out   = '1;
    assign bus.ap_idle     = (state_q == StIdle);
    assign bus.ap_done     = (state_q == StDone);
    assign bus.core_start  = core_start_q;
    assign task_count      = task_count_q;

endmodule

// File: doc/kernel_bc_start_token_issuer.md
# kernel_bc_start_token_issuer

Writer-side controller for the 1-bit start-token FIFOs that chain dataflow processes in the kernel_bc design. It sits in an upstream process, turns that process's ap_start/ap_done/ap_continue block-level handshake into exactly one start token per task for each downstream start FIFO, and launches the local process body. It stalls on any full downstream FIFO and writes no duplicate tokens.

## Interface
- NUM_OUT, 2: number of downstream start FIFOs fed; range 1..8.
- CNT_WIDTH, 16: width of task_count and stall_cycles.

- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high.
- ap_start  in  1  task request from the parent controller.
- ap_ready  out  1  pulse: all tokens for this task written, request consumed.
- ap_idle  out  1  high only in IDLE.
- ap_done  out  1  high in DONE until ap_continue.
- ap_continue  in  1  acknowledges ap_done.
- core_start  out  1  one-cycle pulse launching the process body.
- core_done  in  1  pulse from the process body; sampled only in RUN.
- start_full_n  in  NUM_OUT  per-FIFO full_n.
- start_write  out  NUM_OUT  per-FIFO write strobe, qualified by full_n.
- start_out  out  NUM_OUT  token data, constant 1.
- task_count  out  CNT_WIDTH  completed tasks, wraps modulo 2^CNT_WIDTH.
- stall_cycles  out  CNT_WIDTH  back-pressure cycle counter (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, RUN, DONE. Register sent[NUM_OUT] records which tokens have been written in the current task.
- IDLE: when ap_start=1, clear sent and go to ISSUE; otherwise stay in IDLE.
- ISSUE: start_write[i] = ~sent[i] & start_full_n[i]. A write sets sent[i].
  - If (sent | start_write) is all ones, assert ap_ready this cycle and go to RUN.
  - Otherwise stay in ISSUE. Outputs may complete in any order and in different cycles.
  - Each FIFO receives exactly one token per task.
- RUN: core_start=1 in the first RUN cycle only. When core_done=1, go to DONE.
- DONE: ap_done=1. When ap_continue=1, increment task_count and go to IDLE.
- core_done outside RUN is ignored.
- ap_start is ignored outside IDLE; the next task is accepted only from IDLE.
- start_write is never asserted when the matching start_full_n=0, and never in any state other than ISSUE.
- Reset, including mid-task: state goes to IDLE and sent, task_count and stall_cycles clear. Tokens already written stay in the FIFOs; the downstream side is reset by the same reset.

## Timing
- Reset values: ap_ready=0, ap_idle=1, ap_done=0, core_start=0, start_write=0, task_count=0, stall_cycles=0. start_out is always 1.
- start_write and ap_ready are combinational from state, sent and start_full_n; all other outputs are registered or decoded from state.
- Zero back-pressure, ap_start in cycle 0 (IDLE):
  - cycle 1: ISSUE, start_write all ones, ap_ready=1.
  - cycle 2: RUN, core_start=1.
- core_done in cycle n (RUN) gives ap_done=1 from cycle n+1.
- ap_continue in a DONE cycle m gives ap_idle=1 in cycle m+1.
- Minimum task period is 4 cycles, with ap_start held and ap_continue tied high.
- A start_full_n rise in cycle k permits the write in cycle k, with no added latency.

## Configuration
- KERNEL_BC_START_STALL_CNT_EN: when defined, stall_cycles increments every ISSUE cycle in which some i has ~sent[i] & ~start_full_n[i]. It saturates at all ones and clears only on reset.
- When the macro is not defined, stall_cycles is tied to 0 and no counter logic is built. The port exists in both builds.

## Test plan
- NUM_OUT=2, start_full_n=2'b11, ap_start=1 at cycle 0, core_done at cycle 3, ap_continue=1 -> start_write=2'b11 at cycle 1 only, core_start at cycle 2, ap_done cycles 4, task_count=1 at cycle 5.
- start_full_n=2'b01 for cycles 1-5, then 2'b11 -> start_write[0] at cycle 1, start_write[1] at cycle 6, ap_ready at cycle 6, core_start at cycle 7, stall_cycles=5 with macro, 0 without.
- Hold ap_continue=0 for 10 cycles in DONE while ap_start=1 -> ap_done stays high, no start_write, ap_start ignored, task_count unchanged.
- Pulse core_done in IDLE and ISSUE -> no state change; only a core_done in RUN reaches DONE.
- Assert reset in RUN after the tokens are written -> IDLE next cycle, all outputs at reset values, no extra token on the next task.
- 2^CNT_WIDTH+1 back-to-back tasks with CNT_WIDTH=4 -> task_count wraps to 1, and each FIFO receives exactly 17 tokens.
